// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core: sequences the shared ALU,
// the unified memory port and the register file, and counts retired instructions.
module multicycle_control (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_we,
   output logic        mdr_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  ALUop,
   output logic        alu_force_add,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        illegal,
   output logic [2:0]  state,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   state_t      state_q, state_d;
   logic [31:0] instret_q;
   logic        retire;
   logic [6:0]  opcode;
   logic        unused_instr_bits;

   assign opcode            = instruction[6:0];
   assign unused_instr_bits = ^instruction[31:7];
   assign alu_src_a         = 1'b0;
   assign state             = state_q;
   assign instret           = instret_q;

   always_comb begin
      state_d       = state_q;
      retire        = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      ir_we         = 1'b0;
      mdr_we        = 1'b0;
      pc_we         = 1'b0;
      pc_src        = 2'b00;
      alu_src_b     = 2'b00;
      ALUop         = 2'b00;
      alu_force_add = 1'b0;
      reg_we        = 1'b0;
      wb_sel        = 2'b00;
      illegal       = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (opcode)
               OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_BEQ, OP_JAL: state_d = S_EXEC;
               default:                                               state_d = S_HALT;
            endcase
         end
         S_EXEC: begin
            unique case (opcode)
               OP_R: begin
                  ALUop   = 2'b11;
                  state_d = S_WB;
               end
               OP_I: begin
                  alu_src_b = 2'b01;
                  ALUop     = 2'b10;
                  state_d   = S_WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_b     = 2'b01;
                  ALUop         = 2'b10;
                  alu_force_add = 1'b1;
                  state_d       = S_MEM;
               end
               OP_LUI: begin
                  alu_src_b = 2'b01;
                  state_d   = S_WB;
               end
               OP_BEQ: begin
                  ALUop = 2'b01;
                  if (zero) begin
                     pc_we  = 1'b1;
                     pc_src = 2'b01;
                  end
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               OP_JAL: begin
                  reg_we  = 1'b1;
                  wb_sel  = 2'b10;
                  pc_we   = 1'b1;
                  pc_src  = 2'b10;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               default: state_d = S_HALT;
            endcase
         end
         S_MEM: begin
            // IR is stable here, so only lw or sw can reach this state
            mem_req       = 1'b1;
            mem_addr_sel  = 1'b1;
            alu_force_add = 1'b1;
            alu_src_b     = 2'b01;
            mem_we        = (opcode == OP_STORE);
            if (mem_ready) begin
               if (opcode == OP_STORE) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  mdr_we  = 1'b1;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            reg_we  = 1'b1;
            wb_sel  = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: illegal = 1'b1;
         default: state_d = S_FETCH;
      endcase
      // strobes are suppressed for the whole reset window, not just at the edge
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         ir_we   = 1'b0;
         mdr_we  = 1'b0;
         pc_we   = 1'b0;
         reg_we  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         instret_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_q + {31'd0, retire};
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each instruction is expanded into the
// cycle-by-cycle output pattern it must produce, and every cycle is compared.
module tb_multicycle_control;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_LW   = 32'h0000A103;
   localparam logic [31:0] I_SW   = 32'h0020A023;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_LUI  = 32'h123450B7;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we;
   logic [1:0]  pc_src;
   logic        alu_src_a;
   logic [1:0]  alu_src_b, ALUop;
   logic        alu_force_add, reg_we;
   logic [1:0]  wb_sel;
   logic        illegal;
   logic [2:0]  state;
   logic [31:0] instret;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cycles = 0;
   logic [31:0] model_instret = 32'd0;
   int          lat;

   typedef struct packed {
      logic [2:0] st;
      logic       req, we, asel, irwe, mdrwe, pcwe;
      logic [1:0] pcsrc;
      logic       srca;
      logic [1:0] bsrc, aluop;
      logic       fadd, regwe;
      logic [1:0] wbsel;
      logic       ill;
   } obs_t;

   multicycle_control dut (
      .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
      .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .ALUop(ALUop), .alu_force_add(alu_force_add),
      .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal), .state(state), .instret(instret)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected summary before 500000");
      $fatal(1);
   end

   function automatic obs_t observe();
      obs_t o;
      o.st = state; o.req = mem_req; o.we = mem_we; o.asel = mem_addr_sel;
      o.irwe = ir_we; o.mdrwe = mdr_we; o.pcwe = pc_we; o.pcsrc = pc_src;
      o.srca = alu_src_a; o.bsrc = alu_src_b; o.aluop = ALUop;
      o.fadd = alu_force_add; o.regwe = reg_we; o.wbsel = wb_sel; o.ill = illegal;
      return o;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs just after the falling edge, check, wait a cycle.
   task automatic cyc(input logic [2:0] st, input obs_t e, input logic rdy, input logic z);
      mem_ready = rdy;
      zero      = z;
      #1;
      e.st  = st;
      e.ill = (st == 3'd7);
      chk($sformatf("outputs_cyc%0d", cycles), 32'(observe()), 32'(e));
      chk($sformatf("instret_cyc%0d", cycles), instret, model_instret);
      cycles++;
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic z, output int ncyc);
      obs_t e;
      int   start;
      start       = cycles;
      instruction = ins;
      for (int i = 0; i < fw; i++) begin
         e = '0; e.req = 1'b1;
         cyc(3'd0, e, 1'b0, 1'b0);
      end
      e = '0; e.req = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1;
      cyc(3'd0, e, 1'b1, 1'b0);
      e = '0;
      cyc(3'd1, e, 1'b1, 1'b0);
      e = '0;
      case (ins[6:0])
         7'b0110011, 7'b0010011, 7'b0110111: begin
            if (ins[6:0] == 7'b0110011) e.aluop = 2'b11;
            else if (ins[6:0] == 7'b0010011) begin e.bsrc = 2'b01; e.aluop = 2'b10; end
            else e.bsrc = 2'b01;
            cyc(3'd2, e, 1'b1, 1'b1);
            e = '0; e.regwe = 1'b1;
            cyc(3'd4, e, 1'b1, 1'b0);
            model_instret++;
         end
         7'b0000011, 7'b0100011: begin
            e.bsrc = 2'b01; e.aluop = 2'b10; e.fadd = 1'b1;
            cyc(3'd2, e, 1'b1, 1'b0);
            e = '0; e.req = 1'b1; e.asel = 1'b1; e.fadd = 1'b1; e.bsrc = 2'b01;
            e.we = (ins[6:0] == 7'b0100011);
            for (int i = 0; i < mw; i++) cyc(3'd3, e, 1'b0, 1'b0);
            if (ins[6:0] == 7'b0000011) begin
               e.mdrwe = 1'b1;
               cyc(3'd3, e, 1'b1, 1'b0);
               e = '0; e.regwe = 1'b1; e.wbsel = 2'b01;
               cyc(3'd4, e, 1'b1, 1'b0);
            end else begin
               cyc(3'd3, e, 1'b1, 1'b0);
            end
            model_instret++;
         end
         7'b1100011: begin
            e.aluop = 2'b01;
            if (z) begin e.pcwe = 1'b1; e.pcsrc = 2'b01; end
            cyc(3'd2, e, 1'b0, z);
            model_instret++;
         end
         7'b1101111: begin
            e.regwe = 1'b1; e.wbsel = 2'b10; e.pcwe = 1'b1; e.pcsrc = 2'b10;
            cyc(3'd2, e, 1'b1, 1'b0);
            model_instret++;
         end
         default: begin
            for (int i = 0; i < 20; i++) begin
               e = '0;
               cyc(3'd7, e, 1'(i % 2), 1'(i % 3 == 0));
            end
         end
      endcase
      ncyc = cycles - start;
   endtask

   initial begin
      obs_t e;
      rst = 1'b1; instruction = 32'd0; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_instret", instret, 32'd0);
      chk("reset_illegal", 32'(illegal), 32'd0);
      chk("reset_strobes", {26'd0, mem_req, mem_we, ir_we, mdr_we, pc_we, reg_we}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_instr(I_ADD, 0, 0, 1'b0, lat);  chk("lat_add", lat, 32'd4);
      chk("instret_after_add", instret, 32'd1);
      run_instr(I_LW, 2, 2, 1'b0, lat);   chk("lat_lw_wait2", lat, 32'd9);
      run_instr(I_SW, 0, 0, 1'b0, lat);   chk("lat_sw", lat, 32'd4);
      run_instr(I_SW, 1, 0, 1'b0, lat);   chk("lat_sw_fwait1", lat, 32'd5);
      run_instr(I_BEQ, 0, 0, 1'b1, lat);  chk("lat_beq_taken", lat, 32'd3);
      run_instr(I_BEQ, 0, 0, 1'b0, lat);  chk("lat_beq_not", lat, 32'd3);
      run_instr(I_JAL, 0, 0, 1'b0, lat);  chk("lat_jal", lat, 32'd3);
      run_instr(I_ADDI, 0, 0, 1'b0, lat); chk("lat_addi", lat, 32'd4);
      run_instr(I_LUI, 0, 0, 1'b0, lat);  chk("lat_lui", lat, 32'd4);
      run_instr(I_LW, 0, 0, 1'b0, lat);   chk("lat_lw", lat, 32'd5);
      chk("instret_after_10", instret, 32'd10);

      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      model_instret = 32'hFFFF_FFFF;
      chk("instret_forced", instret, 32'hFFFF_FFFF);
      run_instr(I_JAL, 0, 0, 1'b0, lat);
      chk("instret_wrap", instret, 32'd0);
      chk("instret_wrap_model", model_instret, 32'd0);

      // abort a store while it waits in MEM
      instruction = I_SW;
      e = '0; e.req = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1; cyc(3'd0, e, 1'b1, 1'b0);
      e = '0; cyc(3'd1, e, 1'b0, 1'b0);
      e = '0; e.bsrc = 2'b01; e.aluop = 2'b10; e.fadd = 1'b1; cyc(3'd2, e, 1'b0, 1'b0);
      e = '0; e.req = 1'b1; e.asel = 1'b1; e.fadd = 1'b1; e.bsrc = 2'b01; e.we = 1'b1;
      cyc(3'd3, e, 1'b0, 1'b0);
      mem_ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("midmem_req", {30'd0, mem_req, mem_we}, 32'd0);
      chk("midmem_state", 32'(state), 32'd0);
      chk("midmem_instret", instret, 32'd0);
      model_instret = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      run_instr(I_ADD, 1, 0, 1'b0, lat); chk("lat_add_after_reset", lat, 32'd5);

      run_instr(I_BAD, 0, 0, 1'b0, lat);
      chk("halt_state", 32'(state), 32'd7);
      chk("halt_illegal", 32'(illegal), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("halt_reset_state", 32'(state), 32'd0);
      chk("halt_reset_illegal", 32'(illegal), 32'd0);
      chk("halt_reset_instret", instret, 32'd0);
      model_instret = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      run_instr(I_SW, 0, 1, 1'b0, lat); chk("lat_sw_mwait1", lat, 32'd5);
      chk("instret_final", instret, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle variant of the RV32I core (subset: add, sub, or, slt, addi, ori, slti, lw, sw, lui, beq, jal). Sequences one shared ALU, one unified instruction/data memory port and the register file across FETCH/DECODE/EXEC/MEM/WB states. Drives the 2-bit ALUop consumed by the existing ALU-control decoder, plus datapath mux selects and write strobes. Also keeps a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- instruction  in  32  current IR contents; only [6:0] opcode is used
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = store, 0 = read
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  latch IR and old_pc (the datapath saves the PC of the fetched instruction)
- mdr_we  out  1  latch load data
- pc_we  out  1  PC write strobe
- pc_src  out  2  00 = PC+4 adder, 01 = old_pc+imm (branch), 10 = old_pc+imm (jal)
- alu_src_a  out  1  0 = rs1 register, 1 = old_pc
- alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4
- ALUop  out  2  to ALU control: 00 lui, 01 beq compare, 10 I-type, 11 R-type
- alu_force_add  out  1  overrides ALU control with ADD (4'b0000) for address calculation
- reg_we  out  1  register file write
- wb_sel  out  2  00 = ALU result, 01 = MDR, 10 = old_pc+4 (link)
- illegal  out  1  sticky; unsupported opcode decoded
- state  out  3  current state, for debug
- instret  out  32  retired-instruction count

## Operation
- States, with state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- State and instret are the only registers. All other outputs are combinational from state, opcode, zero and mem_ready.
- Every output not listed for a state is 0.
- FETCH: mem_req=1, mem_addr_sel=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=00, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle; the register file is read.
  - Opcode is one of 0110011, 0010011, 0000011, 0100011, 0110111, 1100011, 1101111: go to EXEC.
  - Any other opcode: go to HALT.
- EXEC, per opcode:
  - R-type: alu_src_b=00, ALUop=11. Go to WB.
  - I-ALU: alu_src_b=01, ALUop=10. Go to WB.
  - lw/sw: alu_src_b=01, ALUop=10, alu_force_add=1. Go to MEM.
  - lui: alu_src_b=01, ALUop=00. Go to WB.
  - beq: alu_src_b=00, ALUop=01. If zero: pc_we=1, pc_src=01. Go to FETCH; the instruction retires.
  - jal: reg_we=1, wb_sel=10, pc_we=1, pc_src=10. Go to FETCH; the instruction retires.
- MEM: mem_req=1, mem_addr_sel=1, alu_force_add=1, alu_src_b=01, mem_we=1 for sw.
  - On mem_ready, sw: go to FETCH; the instruction retires.
  - On mem_ready, lw: mdr_we=1, go to WB.
  - Otherwise stay in MEM.
- WB: reg_we=1, wb_sel=01 for lw, 00 otherwise. Go to FETCH; the instruction retires.
- HALT: illegal=1. No strobes asserted. Left only by reset.
- instret: +1 on each retiring transition. 32-bit wrap: 0xFFFFFFFF → 0.
- rd = x0 needs no special handling; the register file ignores those writes.

## Timing
- Reset (async assert): state=FETCH, instret=0, illegal=0.
  - While rst is high, all strobes (mem_req, mem_we, ir_we, mdr_we, pc_we, reg_we) are forced 0.
  - First cycle after deassert: mem_req=1.
- Handshake rules:
  - mem_req stays high, with mem_addr_sel and mem_we stable, until mem_ready is sampled high.
  - mem_ready in the same cycle as mem_req is legal (zero wait).
  - mem_ready outside FETCH/MEM is ignored.
- Latency at zero wait, FETCH to next FETCH:
  - R, I-ALU, lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, jal: 3 cycles.
  - Each memory wait cycle adds 1.
- zero is sampled only in EXEC of a beq, i.e. the cycle after DECODE.
- Reset asserted mid-MEM or mid-FETCH: the request drops immediately. No partial store commits from the controller side.

## Test plan
- Reset, then an R-type add (0x002081B3) at zero wait:
  - state sequence 0,1,2,4,0.
  - ALUop=11 in EXEC; reg_we=1 for exactly 1 cycle with wb_sel=00.
  - instret 0→1.
- lw (0x0000A103) with mem_ready delayed 2 cycles in both FETCH and MEM:
  - mem_req held 3 cycles in each; mem_addr_sel=1 in MEM; alu_force_add=1 in EXEC/MEM.
  - mdr_we on the ready cycle; then WB with wb_sel=01.
  - 9 cycles total.
- sw (0x0020A023):
  - mem_we=1 only in MEM; reg_we never asserted.
  - Returns to FETCH after ready; instret +1.
- beq (0x00208463):
  - zero=1: pc_we=1, pc_src=01 in EXEC.
  - zero=0: only the FETCH pc_we (pc_src=00) is seen.
  - 3 cycles in both cases.
- jal (0x008000EF):
  - EXEC asserts reg_we=1, wb_sel=10, pc_we=1, pc_src=10 in the same cycle.
- Illegal opcode 0x0000007F:
  - HALT after DECODE; illegal=1 and no strobes for 20 cycles.
  - Async reset returns to FETCH with illegal=0, instret=0.
  - Counter wrap is checked separately by forcing instret=0xFFFFFFFF, then retiring one instruction → 0.
